sr04_scheduler: RTL

Sequences the HC-SR04 ultrasonic controller by issuing its `start` pulses, either on a manual request or continuously. It waits for each `dist_done` with a timeout, enforces the minimum re-trigger period, and averages a burst of 2^AVG_LOG2 samples into one filtered distance. It sits between the debounced start button and the existing `sr04_controller`, and its output feeds the FND display path in place of the raw distance.

---
 rtl/sr04_pkg.sv | 18 +
 rtl/sr04_scheduler_if.sv | 27 ++
 rtl/sr04_period_timer.sv | 32 +++
 rtl/sr04_scheduler.sv | 121 ++++++++++++
 4 files changed

// File: rtl/sr04_pkg.sv
// Shared types and helpers for the HC-SR04 measurement scheduler.
// Holds the FSM state encoding, the default distance width and the ms-to-cycles conversion.
package sr04_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } sr04_state_e;

  localparam int unsigned DIST_W_DEF = 14;

  function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/sr04_scheduler_if.sv
// Scheduler-facing bundle: control inputs, sr04_controller handshake and filtered result.
// The slave side is the scheduler; the master side is whatever drives it.
interface sr04_scheduler_if
  import sr04_pkg::*;
#(
  parameter int unsigned DIST_W = DIST_W_DEF
);
  logic              mode_auto;
  logic              req;
  logic              sr_start;
  logic [DIST_W-1:0] sr_dist;
  logic              sr_done;
  logic [DIST_W-1:0] dist_out;
  logic              dist_valid;
  logic              busy;
  logic              timeout_err;

  modport master (
    output mode_auto, req, sr_dist, sr_done,
    input  sr_start, dist_out, dist_valid, busy, timeout_err
  );

  modport slave (
    input  mode_auto, req, sr_dist, sr_done,
    output sr_start, dist_out, dist_valid, busy, timeout_err
  );
endinterface

// File: rtl/sr04_period_timer.sv
// Cycle counter since the current sr_start; saturates at the period limit and flags timeout/period ends.
// Zero latency flags decoded from the count; clear wins over count enable.
module sr04_period_timer #(
  parameter int unsigned PERIOD_CYC  = 10,
  parameter int unsigned TIMEOUT_CYC = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic timeout_hit,
  output logic period_hit
);
  localparam int unsigned W = $clog2(PERIOD_CYC);
  localparam logic [W-1:0] P_LAST = W'(PERIOD_CYC - 1);
  localparam logic [W-1:0] T_LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] p_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q <= '0;
    end else if (clr) begin
      p_q <= '0;
    end else if (en && (p_q != P_LAST)) begin
      p_q <= p_q + W'(1);
    end
  end

  assign timeout_hit = (p_q == T_LAST);
  assign period_hit  = (p_q == P_LAST);
endmodule

// File: rtl/sr04_scheduler.sv
// Issues sr04_controller start pulses (manual or continuous) and averages 2^AVG_LOG2 samples per burst.
// sr_start one cycle after leaving IDLE, result one cycle after the last sr_done; req while busy is dropped.
module sr04_scheduler
  import sr04_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned PERIOD_MS  = 60,
  parameter int unsigned TIMEOUT_MS = 30,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned DIST_W     = DIST_W_DEF
) (
  input logic             clk,
  input logic             rst,
  sr04_scheduler_if.slave bus
);
  localparam int unsigned PERIOD_CYC  = ms_to_cyc(CLK_HZ, PERIOD_MS);
  localparam int unsigned TIMEOUT_CYC = ms_to_cyc(CLK_HZ, TIMEOUT_MS);
  localparam int unsigned ACC_W       = DIST_W + AVG_LOG2;
  localparam int unsigned CNT_W       = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  sr04_state_e       state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_sum;
  logic [CNT_W-1:0]  cnt_q;
  logic              abort_q, done_q;
  logic [DIST_W-1:0] dist_q;
  logic              valid_q, terr_q;
  logic              timeout_hit, period_hit;
  logic              burst_init, take, last_take, expire;

  // Count restarts on every entry into FIRE so start pulses land exactly PERIOD_CYC apart.
  sr04_period_timer #(
    .PERIOD_CYC  (PERIOD_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (state_q != IDLE),
    .clr         (state_d == FIRE),
    .timeout_hit (timeout_hit),
    .period_hit  (period_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    burst_init = 1'b0;
    take       = 1'b0;
    expire     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req || bus.mode_auto) begin
          state_d    = FIRE;
          burst_init = 1'b1;
        end
      end
      FIRE: state_d = WAIT;
      WAIT: begin
        // A completion arriving on the timeout cycle still counts as a sample.
        if (bus.sr_done) begin
          take    = 1'b1;
          state_d = GAP;
        end else if (timeout_hit) begin
          expire  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (period_hit) state_d = (done_q || abort_q) ? IDLE : FIRE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_take = take && (cnt_q == CNT_LAST);
  assign acc_sum   = acc_q + ACC_W'(bus.sr_dist);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      dist_q  <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      valid_q <= last_take;
      if (burst_init) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        abort_q <= 1'b0;
        done_q  <= 1'b0;
      end
      if (take) begin
        acc_q <= acc_sum;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (last_take) begin
        dist_q <= acc_sum[AVG_LOG2 +: DIST_W];
        done_q <= 1'b1;
      end
      if (expire) begin
        terr_q  <= 1'b1;
        abort_q <= 1'b1;
      end else if (last_take) begin
        terr_q <= 1'b0;
      end
    end
  end

  assign bus.sr_start    = (state_q == FIRE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.dist_out    = dist_q;
  assign bus.dist_valid  = valid_q;
  assign bus.timeout_err = terr_q;
endmodule
